// File: rtl/alu_seq_pkg.sv
// Shared types for the registered sequential ALU and its shift-add multiplier.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    FN_ADD  = 3'b000,
    FN_ORR  = 3'b001,
    FN_ANDR = 3'b010,
    FN_CAT  = 3'b011,
    FN_MUL  = 3'b100,
    FN_ACC  = 3'b101,
    FN_CLR  = 3'b110,
    FN_RSV  = 3'b111
  } func_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle, N steps per product.
module seq_multiplier #(
  parameter int unsigned N = 4
) (
  input  logic             Clock,
  input  logic             Reset_b,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] CountInit = CW'(N);
  localparam logic [CW-1:0] CountOne  = CW'(1);

  logic [2*N-1:0] mcand_q;
  logic [N-1:0]   mplier_q;
  logic [2*N-1:0] partial_q;
  logic [2*N-1:0] partial_d;
  logic [CW-1:0]  count_q;

  always_comb begin
    partial_d = partial_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign busy    = (count_q != '0);
  // Final step: the product is taken from the adder so the caller can latch it on the same edge.
  assign done    = busy && (count_q == CountOne);
  assign product = partial_d;

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      count_q   <= '0;
    end else if (start) begin
      mcand_q   <= {{N{1'b0}}, a};
      mplier_q  <= b;
      partial_q <= '0;
      count_q   <= CountInit;
    end else if (busy) begin
      mcand_q   <= mcand_q << 1;
      mplier_q  <= mplier_q >> 1;
      partial_q <= partial_d;
      count_q   <= count_q - CountOne;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready input, accumulate/clear modes and an iterative multiplier.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic             Clock,
  input  logic             Reset_b,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic [2:0]       Function,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [2*N-1:0]   ALUout,
  output logic             Out_valid,
  output logic             Overflow
);

  state_t         state_q, state_d;
  logic [2*N-1:0] aluout_q, aluout_d;
  logic           overflow_q, overflow_d;
  logic           out_valid_q, out_valid_d;

  logic           mul_start;
  logic           mul_busy;
  logic           mul_done;
  logic [2*N-1:0] mul_product;

  func_t          fn;
  logic [2*N-1:0] add_sum;
  logic [2*N:0]   acc_sum;

  assign fn      = func_t'(Function);
  assign add_sum = {{N{1'b0}}, A} + {{N{1'b0}}, B};
  // ACC reads the result register as it stood before the edge, so chained ACCs compose.
  assign acc_sum = {1'b0, aluout_q} + {{(N + 1){1'b0}}, A};

  seq_multiplier #(
    .N(N)
  ) u_mul (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d     = state_q;
    aluout_d    = aluout_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    mul_start   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (In_valid) begin
          unique case (fn)
            FN_ADD: begin
              aluout_d    = add_sum;
              overflow_d  = 1'b0;
              out_valid_d = 1'b1;
            end
            FN_ORR: begin
              aluout_d    = {{(2 * N - 1){1'b0}}, |{A, B}};
              out_valid_d = 1'b1;
            end
            FN_ANDR: begin
              aluout_d    = {{(2 * N - 1){1'b0}}, &{A, B}};
              out_valid_d = 1'b1;
            end
            FN_CAT: begin
              aluout_d    = {A, B};
              out_valid_d = 1'b1;
            end
            FN_MUL: begin
              mul_start = 1'b1;
              state_d   = S_MUL;
            end
            FN_ACC: begin
              aluout_d    = acc_sum[2*N-1:0];
              overflow_d  = acc_sum[2*N];
              out_valid_d = 1'b1;
            end
            FN_CLR: begin
              aluout_d    = '0;
              overflow_d  = 1'b0;
              out_valid_d = 1'b1;
            end
            FN_RSV: begin
            end
          endcase
        end
      end
      S_MUL: begin
        if (mul_done) begin
          aluout_d    = mul_product;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q     <= S_IDLE;
      aluout_q    <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      aluout_q    <= aluout_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign In_ready  = (state_q == S_IDLE) && !mul_busy;
  assign ALUout    = aluout_q;
  assign Out_valid = out_valid_q;
  assign Overflow  = overflow_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N=4): vector table plus multi-cycle sequences, scoreboarded.
module tb_alu_seq;

  localparam int unsigned N = 4;

  logic           Clock;
  logic           Reset_b;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic [2:0]     Function;
  logic           In_valid;
  logic           In_ready;
  logic [2*N-1:0] ALUout;
  logic           Out_valid;
  logic           Overflow;

  alu_seq #(
    .N(N)
  ) dut (
    .Clock     (Clock),
    .Reset_b   (Reset_b),
    .A         (A),
    .B         (B),
    .Function  (Function),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .ALUout    (ALUout),
    .Out_valid (Out_valid),
    .Overflow  (Overflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [2:0] fn;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] out;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] out;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[9];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  // Scoreboard: every Out_valid pulse must match the oldest outstanding expectation.
  always @(posedge Clock) begin
    #1;
    if (Out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out_valid", 32'(Out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_aluout", 32'(ALUout), 32'(e.out));
        check("sb_overflow", 32'(Overflow), 32'(e.ovf));
      end
    end
  end

  task automatic do_op(input logic [2:0] fn, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp_out, input logic exp_ovf, input bit expect_out);
    exp_t e;
    @(negedge Clock);
    Function = fn;
    A        = a;
    B        = b;
    In_valid = 1'b1;
    check("in_ready_before_accept", 32'(In_ready), 32'd1);
    if (expect_out) begin
      e.out = exp_out;
      e.ovf = exp_ovf;
      sb_q.push_back(e);
    end
    @(posedge Clock);
    #1;
    In_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{fn: 3'b000, a: 4'hF, b: 4'h1, out: 8'h10, ovf: 1'b0};
    vecs[1] = '{fn: 3'b011, a: 4'hA, b: 4'h5, out: 8'hA5, ovf: 1'b0};
    vecs[2] = '{fn: 3'b001, a: 4'h0, b: 4'h0, out: 8'h00, ovf: 1'b0};
    vecs[3] = '{fn: 3'b010, a: 4'hF, b: 4'hF, out: 8'h01, ovf: 1'b0};
    vecs[4] = '{fn: 3'b001, a: 4'h0, b: 4'h1, out: 8'h01, ovf: 1'b0};
    vecs[5] = '{fn: 3'b010, a: 4'hF, b: 4'hE, out: 8'h00, ovf: 1'b0};
    vecs[6] = '{fn: 3'b000, a: 4'h7, b: 4'h8, out: 8'h0F, ovf: 1'b0};
    vecs[7] = '{fn: 3'b101, a: 4'h3, b: 4'h9, out: 8'h12, ovf: 1'b0};
    vecs[8] = '{fn: 3'b011, a: 4'h3, b: 4'hC, out: 8'h3C, ovf: 1'b0};

    Reset_b  = 1'b0;
    In_valid = 1'b0;
    A        = '0;
    B        = '0;
    Function = '0;
    idle_cycles(2);
    @(negedge Clock);
    Reset_b = 1'b1;
    check("reset_aluout", 32'(ALUout), 32'd0);
    check("reset_out_valid", 32'(Out_valid), 32'd0);
    check("reset_overflow", 32'(Overflow), 32'd0);
    check("reset_in_ready", 32'(In_ready), 32'd1);

    // Back-to-back single-cycle ops from the table.
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].ovf, 1'b1);
      check("vec_aluout", 32'(ALUout), 32'(vecs[i].out));
      check("vec_out_valid", 32'(Out_valid), 32'd1);
    end
    idle_cycles(1);
    check("out_valid_one_cycle", 32'(Out_valid), 32'd0);

    // Reserved code leaves everything alone.
    do_op(3'b111, 4'h5, 4'h5, 8'h00, 1'b0, 1'b0);
    check("rsv_aluout", 32'(ALUout), 32'h3C);
    check("rsv_out_valid", 32'(Out_valid), 32'd0);
    check("rsv_in_ready", 32'(In_ready), 32'd1);

    // MUL 15*15 with a second request held while busy.
    do_op(3'b100, 4'hF, 4'hF, 8'hE1, 1'b0, 1'b1);
    check("mul_busy_k", 32'(In_ready), 32'd0);
    check("mul_hold_k", 32'(ALUout), 32'h3C);
    Function = 3'b000;
    A        = 4'h5;
    B        = 4'h6;
    In_valid = 1'b1;
    for (int i = 1; i < 4; i++) begin
      idle_cycles(1);
      check("mul_busy", 32'(In_ready), 32'd0);
      check("mul_hold", 32'(ALUout), 32'h3C);
      check("mul_no_valid", 32'(Out_valid), 32'd0);
    end
    idle_cycles(1);
    check("mul_result", 32'(ALUout), 32'hE1);
    check("mul_valid", 32'(Out_valid), 32'd1);
    check("mul_ready_back", 32'(In_ready), 32'd1);
    begin
      exp_t e;
      e.out = 8'h0B;
      e.ovf = 1'b0;
      sb_q.push_back(e);
    end
    idle_cycles(1);
    In_valid = 1'b0;
    check("held_req_at_k5", 32'(ALUout), 32'h0B);

    // CLR then 17 ACCs of 15, then one that wraps.
    do_op(3'b110, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1);
    begin
      int sum;
      sum = 0;
      for (int i = 0; i < 17; i++) begin
        sum = sum + 15;
        do_op(3'b101, 4'hF, 4'h0, 8'(sum), 1'b0, 1'b1);
      end
    end
    check("acc17", 32'(ALUout), 32'hFF);
    do_op(3'b101, 4'h1, 4'h0, 8'h00, 1'b1, 1'b1);
    check("acc_wrap", 32'(ALUout), 32'h00);
    check("acc_overflow", 32'(Overflow), 32'd1);
    do_op(3'b000, 4'h2, 4'h3, 8'h05, 1'b0, 1'b1);
    check("add_clears_ovf", 32'(Overflow), 32'd0);

    // MUL aborted by reset at k+2: nothing may come out.
    do_op(3'b100, 4'h7, 4'h3, 8'h00, 1'b0, 1'b0);
    idle_cycles(1);
    @(posedge Clock);
    Reset_b = 1'b0;
    #2;
    check("abort_aluout", 32'(ALUout), 32'd0);
    check("abort_in_ready", 32'(In_ready), 32'd1);
    check("abort_out_valid", 32'(Out_valid), 32'd0);
    @(negedge Clock);
    Reset_b = 1'b1;
    idle_cycles(6);
    check("abort_still_zero", 32'(ALUout), 32'd0);

    do_op(3'b100, 4'h7, 4'h3, 8'h15, 1'b0, 1'b1);
    idle_cycles(4);
    check("mul_after_abort", 32'(ALUout), 32'h15);
    idle_cycles(2);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
